mem_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch and the load/store unit. Each requester uses a req/gnt/rvalid handshake; the arbiter forwards one transaction at a time to the memory bus. It routes the response back to the owner of that transaction. A response timeout turns a hung bus into a bus error, so the LSU error path (exception vector offset 16) and the fetch path always complete.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto a single req/gnt/rvalid memory port.
// One transaction in flight; round-robin on ties; response timeout yields a bus error.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           instr_req_i,
    input  logic [`RISCV_ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]          instr_rdata_o,
    output logic                           instr_err_o,
    input  logic                           data_req_i,
    input  logic                           data_we_i,
    input  logic [DATA_WIDTH/8-1:0]        data_be_i,
    input  logic [`RISCV_ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]          data_wdata_i,
    output logic                           data_gnt_o,
    output logic                           data_rvalid_o,
    output logic [DATA_WIDTH-1:0]          data_rdata_o,
    output logic                           data_err_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [DATA_WIDTH/8-1:0]        mem_be_o,
    output logic [`RISCV_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    input  logic                           mem_err_i,
    output logic                           busy_o
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_INSTR, WAIT_DATA} state_t;

    state_t          state, state_nxt;
    logic            last_data, last_data_nxt;
    logic            lock, lock_sel;
    logic [TW-1:0]   timer, timer_nxt;
    logic            sel_data, sel_req, gnt_fire, timeout_hit, rsp_fire;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic            rsp_err;

    // A stalled request keeps its owner so the bus fields cannot change before grant.
    always_comb begin
        if (lock)
            sel_data = lock_sel;
        else if (instr_req_i && data_req_i)
            sel_data = !last_data;
        else
            sel_data = data_req_i;
        sel_req = sel_data ? data_req_i : instr_req_i;
    end

    assign mem_req_o   = (state == IDLE) && sel_req;
    assign gnt_fire    = mem_req_o && mem_gnt_i;
    assign instr_gnt_o = gnt_fire && !sel_data;
    assign data_gnt_o  = gnt_fire && sel_data;
    assign busy_o      = (state != IDLE);

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel_data) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    // A real response arriving in the timeout cycle takes precedence.
    assign timeout_hit = (TIMEOUT > 0) && (timer == TW'(TIMEOUT - 1)) && !mem_rvalid_i;
    assign rsp_fire    = (state != IDLE) && (mem_rvalid_i || timeout_hit);
    assign rsp_rdata   = mem_rvalid_i ? mem_rdata_i : '0;
    assign rsp_err     = mem_rvalid_i ? mem_err_i : 1'b1;

    assign instr_rvalid_o = rsp_fire && (state == WAIT_INSTR);
    assign data_rvalid_o  = rsp_fire && (state == WAIT_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? rsp_rdata : '0;
    assign data_rdata_o   = data_rvalid_o ? rsp_rdata : '0;
    assign instr_err_o    = instr_rvalid_o && rsp_err;
    assign data_err_o     = data_rvalid_o && rsp_err;

    always_comb begin
        state_nxt     = state;
        last_data_nxt = last_data;
        timer_nxt     = timer;
        case (state)
            IDLE: begin
                if (gnt_fire) begin
                    state_nxt     = sel_data ? WAIT_DATA : WAIT_INSTR;
                    last_data_nxt = sel_data;
                    timer_nxt     = '0;
                end
            end
            WAIT_INSTR, WAIT_DATA: begin
                if (rsp_fire) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_data <= 1'b1;
            timer     <= '0;
            lock      <= 1'b0;
            lock_sel  <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_data <= last_data_nxt;
            timer     <= timer_nxt;
            lock      <= mem_req_o && !mem_gnt_i;
            lock_sel  <= sel_data;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i, data_req_i, data_we_i;
    logic [31:0] instr_addr_i, data_addr_i, data_wdata_i;
    logic [3:0]  data_be_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o)
    );

    typedef struct {bit data; logic [31:0] addr; bit we; logic [3:0] be; logic [31:0] wdata;} gnt_t;
    typedef struct {bit data; logic [31:0] rdata; bit err;} rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    gnt_t g;
    rsp_t r;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_g(input bit d, input logic [31:0] a, input bit we, input logic [3:0] be,
                          input logic [31:0] wd);
        gq.push_back('{d, a, we, be, wd});
    endtask

    task automatic push_r(input bit d, input logic [31:0] rd, input bit err);
        rq.push_back('{d, rd, err});
    endtask

    task automatic clr();
        instr_req_i = 0; instr_addr_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every grant and every response must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_gnt_o || data_gnt_o) begin
                if (gq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_gnt instr=%0b data=%0b", instr_gnt_o, data_gnt_o);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_owner", data_gnt_o, g.data);
                    chk("gnt_both", instr_gnt_o & data_gnt_o, 0);
                    chk("gnt_addr", mem_addr_o, g.addr);
                    chk("gnt_we", mem_we_o, g.we);
                    chk("gnt_be", mem_be_o, g.be);
                    chk("gnt_wdata", mem_wdata_o, g.wdata);
                end
            end
            if (instr_rvalid_o || data_rvalid_o) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rvalid instr=%0b data=%0b", instr_rvalid_o, data_rvalid_o);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_owner", data_rvalid_o, r.data);
                    chk("rsp_rdata", r.data ? data_rdata_o : instr_rdata_o, r.rdata);
                    chk("rsp_err", r.data ? data_err_o : instr_err_o, r.err);
                    chk("rsp_other_quiet", r.data ? {instr_rvalid_o, instr_err_o, |instr_rdata_o}
                                                  : {data_rvalid_o, data_err_o, |data_rdata_o}, 0);
                end
            end else begin
                chk("idle_rsp", {instr_err_o, data_err_o, |instr_rdata_o, |data_rdata_o}, 0);
            end
        end
    end

    task automatic rst_mid(input bit d);
        if (d) begin
            data_req_i = 1; data_addr_i = 32'h600; data_be_i = 4'hF;
            push_g(1, 32'h600, 0, 4'hF, 0);
        end else begin
            instr_req_i = 1; instr_addr_i = 32'h700;
            push_g(0, 32'h700, 0, 4'hF, 0);
        end
        mem_gnt_i = 1;
        smp(); adv(); clr();
        smp(); chk("t6_busy_pre", busy_o, 1); adv();
        rst = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h99;
        smp();
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_outs", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                            instr_err_o, data_err_o, |instr_rdata_o, |data_rdata_o}, 0);
        adv(); rst = 0; clr();
        // first tie after reset must go to instr
        instr_req_i = 1; instr_addr_i = 32'h800;
        data_req_i = 1; data_addr_i = 32'h900; data_be_i = 4'hF;
        mem_gnt_i = 1; push_g(0, 32'h800, 0, 4'hF, 0);
        smp(); adv();
        instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h88;
        push_r(0, 32'h88, 0);
        smp(); adv();
        mem_rvalid_i = 0; mem_gnt_i = 1; push_g(1, 32'h900, 0, 4'hF, 0);
        smp(); adv(); clr();
        mem_rvalid_i = 1; mem_rdata_i = 32'h99; push_r(1, 32'h99, 0);
        smp(); adv(); clr();
    endtask

    initial begin
        rst = 1; clr();
        smp();
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_gnt_rvalid", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                               instr_err_o, data_err_o}, 0);
        chk("rst_bus", {mem_we_o, mem_be_o, |mem_addr_o, |mem_wdata_o}, 0);
        adv(); rst = 0;

        // T1: single fetch
        instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
        push_g(0, 32'h100, 0, 4'hF, 0);
        smp(); chk("t1_mem_req", mem_req_o, 1); chk("t1_busy_c0", busy_o, 0);
        adv(); clr();
        smp(); chk("t1_busy_c1", busy_o, 1); chk("t1_req_in_wait", mem_req_o, 0);
        adv(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; push_r(0, 32'hDEADBEEF, 0);
        smp(); chk("t1_busy_c2", busy_o, 1);
        adv(); clr();
        smp(); chk("t1_busy_c3", busy_o, 0);
        adv();

        // T2: round-robin from reset
        rst = 1; adv(); rst = 0;
        instr_req_i = 1; instr_addr_i = 32'h1000;
        data_req_i = 1; data_addr_i = 32'h2000; data_we_i = 1; data_be_i = 4'hC;
        data_wdata_i = 32'hAAAA5555; mem_gnt_i = 1;
        for (int c = 0; c < 8; c++) begin
            mem_rvalid_i = (c % 2 == 1);
            mem_rdata_i = 32'h1000 + c;
            if (c % 2 == 0) begin
                if (c % 4 == 2) push_g(1, 32'h2000, 1, 4'hC, 32'hAAAA5555);
                else            push_g(0, 32'h1000, 0, 4'hF, 0);
            end else begin
                push_r(c % 4 == 3, 32'h1000 + c, 0);
            end
            smp();
            if (c % 2 == 0) chk("t2_addr", mem_addr_o, (c % 4 == 2) ? 32'h2000 : 32'h1000);
            adv();
        end
        clr();

        // T3: stalled data write keeps selection locked while instr arrives
        data_req_i = 1; data_we_i = 1; data_addr_i = 32'h200; data_be_i = 4'b0011;
        data_wdata_i = 32'h1234;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) begin instr_req_i = 1; instr_addr_i = 32'h300; end
            mem_gnt_i = (c == 3);
            if (c == 3) push_g(1, 32'h200, 1, 4'b0011, 32'h1234);
            smp();
            chk("t3_lock_req", mem_req_o, 1);
            chk("t3_lock_addr", mem_addr_o, 32'h200);
            chk("t3_lock_we_be", {mem_we_o, mem_be_o}, {1'b1, 4'b0011});
            chk("t3_lock_wdata", mem_wdata_o, 32'h1234);
            chk("t3_no_instr_gnt", instr_gnt_o, 0);
            adv();
        end
        data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        push_r(1, 32'h55, 0);
        smp(); chk("t3_instr_waits", {instr_gnt_o, mem_req_o}, 0);
        adv();
        mem_rvalid_i = 0; mem_gnt_i = 1; push_g(0, 32'h300, 0, 4'hF, 0);
        smp(); adv();
        instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h66;
        push_r(0, 32'h66, 0);
        smp(); adv(); clr();

        // T4: timeout on an LSU read, late response dropped
        data_req_i = 1; data_addr_i = 32'h400; data_be_i = 4'hF; mem_gnt_i = 1;
        push_g(1, 32'h400, 0, 4'hF, 0);
        smp(); adv(); clr();
        for (int c = 1; c < 16; c++) begin
            smp(); chk("t4_no_early_rvalid", data_rvalid_o, 0); adv();
        end
        push_r(1, 32'h0, 1);
        smp(); chk("t4_busy_at_to", busy_o, 1);
        adv();
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        smp(); chk("t4_late_dropped", data_rvalid_o, 0); chk("t4_idle", busy_o, 0);
        adv(); clr();

        // T5: fetch bus error; rvalid in the grant cycle is ignored
        instr_req_i = 1; instr_addr_i = 32'h500; mem_gnt_i = 1;
        mem_rvalid_i = 1; mem_rdata_i = 32'hEEEE;
        push_g(0, 32'h500, 0, 4'hF, 0);
        smp(); adv(); clr();
        mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'hBAD; push_r(0, 32'hBAD, 1);
        smp(); adv();
        mem_rvalid_i = 0;
        smp(); chk("t5_err_one_cycle", instr_err_o, 0);
        adv(); clr();

        // T6: reset inside WAIT_DATA and inside WAIT_INSTR
        rst_mid(1);
        rst_mid(0);

        chk("gq_drained", gq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
